note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_seq_pkg.sv | 27 ++
 rtl/sample_tick_gen.sv | 30 +++
 rtl/note_sequencer.sv | 111 +++++++++++
 tb/tb_note_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: FSM state encoding,
// the fixed 16-entry note ROM and the default sample-tick divider.
package note_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_GAP,
      ST_DONE
   } seq_state_e;

   localparam logic [7:0] REST_CODE          = 8'h00;
   localparam int         DEFAULT_SAMPLE_DIV = 1134;
   localparam int         ROM_DEPTH          = 16;

   // Entry 1 is deliberately a rest so the timed-silence path is exercised.
   localparam logic [7:0] NOTE_ROM [ROM_DEPTH] = '{
      8'h3C, 8'h00, 8'h40, 8'h43, 8'h48, 8'h00, 8'h47, 8'h43,
      8'h45, 8'h41, 8'h00, 8'h3E, 8'h40, 8'h3C, 8'h00, 8'h3C
   };

   function automatic logic is_rest(input logic [7:0] code);
      return code == REST_CODE;
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: while enabled, counts 0..DIV-1 and flags the last
// count as a one-cycle tick; held at zero whenever disabled.
module sample_tick_gen #(
   parameter int DIV = 1134
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_cnt <= '0;
      end else if (!en || div_cnt == LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // en is a decode of the sequencer state register, so tick has no input path.
   assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Steps through NOTE_ROM, timing each note with an external duration counter
// fed by sample ticks, with a one-cycle articulation gap between notes.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | one cycle: latch ROM code, pulse note_change to clear the counter
//   PLAY  | issue sample ticks until count_done
//   GAP   | one silent cycle, then next note, loop, or finish
//   DONE  | one cycle: pulse seq_done, then IDLE
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
   parameter int SEQ_LEN    = 16,
   parameter bit LOOP_EN    = 1'b0
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       start,
   input  logic       stop,
   input  logic       count_done,
   output logic       count_inc,
   output logic       note_change,
   output logic [7:0] note_code,
   output logic [3:0] note_idx,
   output logic       note_gate,
   output logic       busy,
   output logic       seq_done
);

   localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);

   seq_state_e state;
   seq_state_e state_nxt;
   logic [3:0] idx_nxt;
   logic [7:0] code_nxt;
   logic       play_en;

   always_comb begin
      state_nxt = state;
      idx_nxt   = note_idx;
      code_nxt  = note_code;
      if (stop) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state_nxt = ST_LOAD;
                  idx_nxt   = '0;
               end
            end
            ST_LOAD: begin
               state_nxt = ST_PLAY;
               code_nxt  = NOTE_ROM[note_idx];
            end
            ST_PLAY: begin
               if (count_done) begin
                  state_nxt = ST_GAP;
               end
            end
            ST_GAP: begin
               if (note_idx < LAST_IDX) begin
                  state_nxt = ST_LOAD;
                  idx_nxt   = note_idx + 4'd1;
               end else if (LOOP_EN) begin
                  state_nxt = ST_LOAD;
                  idx_nxt   = '0;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with state.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= ST_IDLE;
         note_idx    <= '0;
         note_code   <= REST_CODE;
         note_change <= 1'b0;
         note_gate   <= 1'b0;
         busy        <= 1'b0;
         seq_done    <= 1'b0;
      end else begin
         state       <= state_nxt;
         note_idx    <= idx_nxt;
         note_code   <= code_nxt;
         note_change <= (state_nxt == ST_LOAD);
         note_gate   <= (state_nxt == ST_PLAY) && !is_rest(code_nxt);
         busy        <= (state_nxt != ST_IDLE);
         seq_done    <= (state_nxt == ST_DONE);
      end
   end

   assign play_en = (state == ST_PLAY);

   sample_tick_gen #(
      .DIV (SAMPLE_DIV)
   ) u_tick (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .en      (play_en),
      .tick    (count_inc)
   );

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: DIV=4, three notes, duration counter
// that raises count_done after five ticks. Instance a plays once, b loops.
module tb_note_sequencer;

   localparam int DIV = 4;
   localparam int LEN = 3;
   localparam int DUR = 5;

   logic Clk = 1'b0;
   logic Reset_n = 1'b1;
   logic start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
   logic count_done_a, count_done_b;
   logic count_inc_a, note_change_a, note_gate_a, busy_a, seq_done_a;
   logic count_inc_b, note_change_b, note_gate_b, busy_b, seq_done_b;
   logic [7:0] note_code_a, note_code_b;
   logic [3:0] note_idx_a, note_idx_b;

   int checks = 0;
   int failures = 0;
   int dcnt_a, dcnt_b;
   int ticks_a = 0, done_a = 0, done_b = 0, overlap_err = 0;

   always #5 Clk = ~Clk;

   note_sequencer #(.SAMPLE_DIV(DIV), .SEQ_LEN(LEN), .LOOP_EN(1'b0)) dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .start(start_a), .stop(stop_a),
      .count_done(count_done_a), .count_inc(count_inc_a),
      .note_change(note_change_a), .note_code(note_code_a),
      .note_idx(note_idx_a), .note_gate(note_gate_a), .busy(busy_a),
      .seq_done(seq_done_a));

   note_sequencer #(.SAMPLE_DIV(DIV), .SEQ_LEN(LEN), .LOOP_EN(1'b1)) dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .start(start_b), .stop(stop_b),
      .count_done(count_done_b), .count_inc(count_inc_b),
      .note_change(note_change_b), .note_code(note_code_b),
      .note_idx(note_idx_b), .note_gate(note_gate_b), .busy(busy_b),
      .seq_done(seq_done_b));

   // Behavioural note-duration counters
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) dcnt_a <= 0;
      else if (note_change_a) dcnt_a <= 0;
      else if (count_inc_a) dcnt_a <= dcnt_a + 1;
   end
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) dcnt_b <= 0;
      else if (note_change_b) dcnt_b <= 0;
      else if (count_inc_b) dcnt_b <= dcnt_b + 1;
   end
   assign count_done_a = (dcnt_a >= DUR);
   assign count_done_b = (dcnt_b >= DUR);

   always @(negedge Clk) begin
      if (Reset_n) begin
         ticks_a = ticks_a + int'(count_inc_a);
         done_a  = done_a + int'(seq_done_a);
         done_b  = done_b + int'(seq_done_b);
         if ((count_inc_a && note_change_a) || (count_inc_b && note_change_b)) begin
            overlap_err = overlap_err + 1;
            $display("FAIL overlap count_inc and note_change both high at t=%0t", $time);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic b, input logic nc, input logic ci,
                        input logic g, input logic [3:0] idx, input logic d,
                        input logic [7:0] code);
      chk({tag, ".busy"}, busy_a, b);
      chk({tag, ".note_change"}, note_change_a, nc);
      chk({tag, ".count_inc"}, count_inc_a, ci);
      chk({tag, ".note_gate"}, note_gate_a, g);
      chk({tag, ".note_idx"}, note_idx_a, idx);
      chk({tag, ".seq_done"}, seq_done_a, d);
      chk({tag, ".note_code"}, note_code_a, code);
   endtask

   typedef struct {
      int         cyc;
      logic       st;
      logic       sp;
      logic       busy;
      logic       nc;
      logic       ci;
      logic       gate;
      logic [3:0] idx;
      logic       done;
      logic [7:0] code;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int cur;
      int t0, d0, db0;
      bit found;

      // cyc = edges after the start edge; outputs checked #1 after that edge
      vecs.push_back('{ 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00});
      vecs.push_back('{ 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 8'h3C});
      vecs.push_back('{ 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 8'h3C});
      vecs.push_back('{ 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 8'h3C});
      vecs.push_back('{ 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 8'h3C});
      vecs.push_back('{21, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 8'h3C});
      vecs.push_back('{22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 8'h3C});
      vecs.push_back('{23, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h3C});
      vecs.push_back('{24, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 8'h3C});
      vecs.push_back('{25, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00});
      vecs.push_back('{28, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00});
      vecs.push_back('{30, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00});
      vecs.push_back('{31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00});
      vecs.push_back('{44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00});
      vecs.push_back('{45, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00});
      vecs.push_back('{46, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00});
      vecs.push_back('{47, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 8'h00});
      vecs.push_back('{48, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 8'h40});
      vecs.push_back('{67, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 8'h40});
      vecs.push_back('{69, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 8'h40});
      vecs.push_back('{70, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 8'h40});
      vecs.push_back('{71, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 8'h40});

      // Asynchronous reset before any clock edge
      #1 Reset_n = 1'b0;
      #1;
      chk_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      step();

      // Single pass on instance a
      t0 = ticks_a;
      d0 = done_a;
      cur = 0;
      foreach (vecs[i]) begin
         while (cur < vecs[i].cyc - 1) begin
            step();
            cur++;
         end
         start_a = vecs[i].st;
         stop_a  = vecs[i].sp;
         step();
         cur++;
         start_a = 1'b0;
         stop_a  = 1'b0;
         chk_a($sformatf("vec%0d_cyc%0d", i, vecs[i].cyc), vecs[i].busy, vecs[i].nc,
               vecs[i].ci, vecs[i].gate, vecs[i].idx, vecs[i].done, vecs[i].code);
      end
      repeat (3) step();
      chk("pass_total_ticks", ticks_a - t0, 3 * DUR);
      chk("pass_seq_done_count", done_a - d0, 1);

      // Looping instance b: after note 2 the index wraps to 0 with no seq_done
      db0 = done_b;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      chk("loop_load0.note_change", note_change_b, 1'b1);
      repeat (68) step();
      chk("loop_gap2.busy", busy_b, 1'b1);
      chk("loop_gap2.note_idx", note_idx_b, 4'd2);
      chk("loop_gap2.note_gate", note_gate_b, 1'b0);
      step();
      chk("loop_wrap.note_change", note_change_b, 1'b1);
      chk("loop_wrap.note_idx", note_idx_b, 4'd0);
      chk("loop_wrap.seq_done", seq_done_b, 1'b0);
      step();
      chk("loop_replay.note_code", note_code_b, 8'h3C);
      chk("loop_replay.note_gate", note_gate_b, 1'b1);
      repeat (5) step();
      chk("loop_seq_done_count", done_b - db0, 0);
      stop_b = 1'b1;
      step();
      stop_b = 1'b0;
      chk("loop_stop.busy", busy_b, 1'b0);

      // Stop coinciding with count_done during note 1
      d0 = done_a;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         if (note_idx_a == 4'd1 && count_done_a && !note_change_a && busy_a) found = 1'b1;
         else step();
      end
      chk("stop_wait_count_done", found, 1'b1);
      stop_a = 1'b1;
      step();
      stop_a = 1'b0;
      chk_a("stop_cd", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00);
      repeat (3) step();
      chk("stop_cd_idle.busy", busy_a, 1'b0);
      chk("stop_cd_seq_done_count", done_a - d0, 0);

      // Reset dropped between edges in the middle of PLAY
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      repeat (7) step();
      chk("prereset.note_gate", note_gate_a, 1'b1);
      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      chk_a("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      @(negedge Clk);
      Reset_n = 1'b1;
      step();
      step();
      chk("post_reset_idle.busy", busy_a, 1'b0);
      chk("post_reset_idle.note_change", note_change_a, 1'b0);
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      chk_a("restart_load", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      step();
      chk_a("restart_play", 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 8'h3C);

      chk("no_inc_change_overlap", overlap_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
